fb_write_scheduler: RTL and testbench

Schedules Mandelbrot pixel results into the QSPI/RP2040 framebuffer without disturbing the display. It buffers 4-bit gray pixels from the compute engine in a small FIFO. During each vertical blanking window it switches the framebuffer driver into write mode, drains the FIFO with the driver's write_data/wrote_data handshake, and leaves write mode before visible lines resume. It sits between the pixel engine and `vga_rp2040_framebuffer`, driving that block's write-side inputs.

---
 rtl/fb_write_scheduler_pkg.sv | 25 ++
 rtl/fb_write_scheduler_if.sv | 29 ++
 rtl/fb_write_scheduler_pixel_fifo.sv | 55 +++++
 rtl/fb_write_scheduler.sv | 173 +++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// Shared types and constants for the framebuffer write scheduler.
//   pix_entry_t      : one buffered pixel, {first, data}
//   wr_state_e       : write FSM state encoding
//   FB_ENTRY_LATENCY : cycles from write_mode rise to the framebuffer's first ack
package fb_write_scheduler_pkg;

  localparam int unsigned PIX_W            = 4;
  localparam int unsigned FB_ENTRY_LATENCY = 17;

  typedef struct packed {
    logic             first;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

  localparam int unsigned PIX_ENTRY_W = $bits(pix_entry_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_READY,
    ST_WAIT_ACK,
    ST_EXIT
  } wr_state_e;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Pixel-stream and framebuffer write-side signals of the scheduler.
//   pix_valid/pix_data/pix_first/pix_ready : pixel engine -> scheduler
//   write_mode/write_data_out/reset_write_ptr/write_data/wrote_data : scheduler <-> framebuffer
// master: environment side (pixel engine + framebuffer); slave: the scheduler.
interface fb_write_scheduler_if;
  import fb_write_scheduler_pkg::*;

  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_first;
  logic             pix_ready;

  logic             write_mode;
  logic [PIX_W-1:0] write_data_out;
  logic             reset_write_ptr;
  logic             write_data;
  logic             wrote_data;

  modport master (
    output pix_valid, pix_data, pix_first, wrote_data,
    input  pix_ready, write_mode, write_data_out, reset_write_ptr, write_data
  );

  modport slave (
    input  pix_valid, pix_data, pix_first, wrote_data,
    output pix_ready, write_mode, write_data_out, reset_write_ptr, write_data
  );

endinterface

// File: rtl/fb_write_scheduler_pixel_fifo.sv
// Small synchronous FIFO with registered occupancy count.
//   clk, rst    : clock, synchronous active-high reset
//   push/wdata  : write side (ignored when full)
//   pop/rdata   : read side, rdata shows the head entry (ignored when empty)
//   full, empty : decoded from count
//   count       : occupancy, 0..DEPTH
module pixel_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Buffers gray pixels and writes them into the framebuffer only during the
// vertical blanking window, using the write_data/wrote_data handshake.
//   clk, rst    : clock, synchronous active-high reset
//   v_sync      : vertical sync; its rising edge opens a write window
//   bus         : pixel stream in, framebuffer write side out (slave modport)
//   window_open : write window active (remaining window > GUARD_CYCLES)
//   ack_error   : sticky, framebuffer ack timed out
//   fifo_level  : pixel FIFO occupancy
module fb_write_scheduler
  import fb_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned WINDOW_CYCLES = 24000,
  parameter int unsigned GUARD_CYCLES  = 64,
  parameter int unsigned ACK_TIMEOUT   = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          v_sync,
  fb_write_scheduler_if.slave           bus,
  output logic                          window_open,
  output logic                          ack_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  // Pixel FIFO
  pix_entry_t fifo_wdata;
  pix_entry_t fifo_rdata;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign fifo_wdata    = {bus.pix_first, bus.pix_data};
  assign bus.pix_ready = !fifo_full;

  pixel_fifo #(
    .WIDTH (PIX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.pix_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level)
  );

  // Write window: loaded on v_sync rise, counts down and saturates at 0.
  logic             v_sync_q;
  logic             vs_rise;
  logic [WIN_W-1:0] win_cnt;

  assign vs_rise = v_sync && !v_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_sync_q    <= 1'b0;
      win_cnt     <= '0;
      window_open <= 1'b0;
    end else begin
      v_sync_q <= v_sync;
      if (vs_rise)              win_cnt <= WIN_W'(WINDOW_CYCLES);
      else if (win_cnt != '0)   win_cnt <= win_cnt - WIN_W'(1);
      window_open <= (32'(win_cnt) > GUARD_CYCLES);
    end
  end

  // Write FSM
  wr_state_e        state, state_next;
  logic [TMR_W-1:0] ack_tmr, ack_tmr_next;
  logic             ack_expired;
  logic             issue;
  logic             write_mode_q, write_mode_next;
  logic             write_data_q, write_data_next;
  logic [PIX_W-1:0] wdo_q, wdo_next;
  logic             rwp_q, rwp_next;
  logic             ack_error_next;

  assign ack_expired         = (ack_tmr == TMR_W'(ACK_TIMEOUT - 1));
  assign bus.write_mode      = write_mode_q;
  assign bus.write_data      = write_data_q;
  assign bus.write_data_out  = wdo_q;
  assign bus.reset_write_ptr = rwp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ack_tmr      <= '0;
      write_mode_q <= 1'b0;
      write_data_q <= 1'b0;
      wdo_q        <= '0;
      rwp_q        <= 1'b0;
      ack_error    <= 1'b0;
    end else begin
      state        <= state_next;
      ack_tmr      <= ack_tmr_next;
      write_mode_q <= write_mode_next;
      write_data_q <= write_data_next;
      wdo_q        <= wdo_next;
      rwp_q        <= rwp_next;
      ack_error    <= ack_error_next;
    end
  end

  always_comb begin
    state_next      = state;
    ack_tmr_next    = ack_tmr;
    issue           = 1'b0;
    fifo_pop        = 1'b0;
    write_data_next = 1'b0;
    wdo_next        = wdo_q;
    rwp_next        = rwp_q;
    ack_error_next  = ack_error;

    case (state)
      ST_IDLE: begin
        ack_tmr_next = '0;
        if (window_open && !fifo_empty) state_next = ST_ENTER;
      end
      ST_ENTER: begin
        if (bus.wrote_data)    state_next = ST_READY;
        else if (!window_open) state_next = ST_EXIT;
        else if (ack_expired) begin
          ack_error_next = 1'b1;
          state_next     = ST_EXIT;
        end else begin
          ack_tmr_next = ack_tmr + TMR_W'(1);
        end
      end
      ST_READY: begin
        if (!window_open || fifo_empty) state_next = ST_EXIT;
        else                            issue      = 1'b1;
      end
      ST_WAIT_ACK: begin
        // An ack with work pending issues the next write directly, giving
        // the 3-cycle strobe cadence; otherwise READY decides to leave.
        if (bus.wrote_data) begin
          if (window_open && !fifo_empty) issue      = 1'b1;
          else                            state_next = ST_READY;
        end else if (ack_expired) begin
          ack_error_next = 1'b1;
          state_next     = ST_EXIT;
        end else begin
          ack_tmr_next = ack_tmr + TMR_W'(1);
        end
      end
      ST_EXIT: begin
        rwp_next   = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (issue) begin
      fifo_pop        = 1'b1;
      wdo_next        = fifo_rdata.data;
      rwp_next        = fifo_rdata.first;
      write_data_next = 1'b1;
      ack_tmr_next    = '0;
      state_next      = ST_WAIT_ACK;
    end

    write_mode_next = (state_next == ST_ENTER) || (state_next == ST_READY) ||
                      (state_next == ST_WAIT_ACK);
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: random pixel traffic, a
// framebuffer ack model, and a queue/window reference model.
module tb_fb_write_scheduler;
  import fb_write_scheduler_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned WIN    = 200;
  localparam int unsigned GUARD  = 64;
  localparam int unsigned ACK_TO = 63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v_sync = 1'b0;
  logic       window_open;
  logic       ack_error;
  logic [4:0] fifo_level;

  fb_write_scheduler_if bus();

  fb_write_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .WINDOW_CYCLES (WIN),
    .GUARD_CYCLES  (GUARD),
    .ACK_TIMEOUT   (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .v_sync      (v_sync),
    .bus         (bus),
    .window_open (window_open),
    .ack_error   (ack_error),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [4:0] exp_q[$];
  logic [4:0] strobe_log[$];
  int         n_strobes = 0;
  int         coinc     = 0;
  int         rem       = 0;
  bit         silent    = 1'b0;

  // Framebuffer ack model: first ack 17 cycles after write_mode rises,
  // then an ack two cycles after every write strobe.
  initial begin : ack_model
    int enter_cnt;
    int ack_cnt;
    bit wm_prev;
    enter_cnt = 0;
    ack_cnt   = 0;
    wm_prev   = 1'b0;
    bus.wrote_data = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wrote_data = 1'b0;
      if (!bus.write_mode) begin
        enter_cnt = 0;
        ack_cnt   = 0;
      end else begin
        if (!wm_prev) enter_cnt = FB_ENTRY_LATENCY;
        else if (enter_cnt > 0) begin
          enter_cnt--;
          if (enter_cnt == 0) bus.wrote_data = 1'b1;
        end
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) bus.wrote_data = 1'b1;
        end
        if (bus.write_data && !silent) ack_cnt = 2;
      end
      wm_prev = bus.write_mode;
    end
  end

  // Monitor: pixel order scoreboard, occupancy, window timing, strobe rules.
  initial begin : monitor
    logic       s_rst, s_vs, s_push;
    logic [4:0] s_ent, e;
    bit         vprev;
    int         old_rem, cyc, last_strobe;
    vprev = 1'b0;
    cyc = 0;
    last_strobe = -100;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_vs   = v_sync;
      s_push = bus.pix_valid && bus.pix_ready;
      s_ent  = {bus.pix_first, bus.pix_data};
      @(posedge clk);
      #2;
      cyc++;
      if (s_rst) begin
        exp_q.delete();
        rem = 0;
        vprev = 1'b0;
        last_strobe = -100;
      end else begin
        old_rem = rem;
        if (s_vs && !vprev) rem = WIN;
        else if (rem > 0) rem--;
        vprev = s_vs;
        check("window_open", window_open, 32'(old_rem > int'(GUARD)));
        if (bus.write_data) begin
          n_strobes++;
          strobe_log.push_back({bus.reset_write_ptr, bus.write_data_out});
          check("strobe_write_mode", bus.write_mode, 1);
          check("strobe_guard", 32'(rem >= int'(GUARD) - 1), 1);
          check("strobe_spacing", 32'(cyc - last_strobe >= 3), 1);
          last_strobe = cyc;
          if (s_push) coinc++;
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", {bus.reset_write_ptr, bus.write_data_out}, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("strobe_pixel", {bus.reset_write_ptr, bus.write_data_out}, e);
          end
        end
        if (s_push) exp_q.push_back(s_ent);
        check("fifo_level", fifo_level, exp_q.size());
        if (rem == 0) check("write_mode_closed", bus.write_mode, 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic push_pix(input logic f, input logic [3:0] d);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    bus.pix_valid = 1'b1;
    bus.pix_first = f;
    bus.pix_data  = d;
    while (!acc && waited < 2000) begin
      @(negedge clk);
      acc = bus.pix_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    check("push_accept", acc, 1);
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      cycles(1);
      got = bus.write_data;
    end
    check(tag, got, 1);
  endtask

  task automatic wait_wm_fall(input string tag, input int budget);
    bit seen, fell;
    seen = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < budget && !fell; i++) begin
      cycles(1);
      if (bus.write_mode) seen = 1'b1;
      else if (seen) fell = 1'b1;
    end
    check(tag, fell, 1);
  endtask

  initial begin : stimulus
    logic [4:0] t1_exp [3];
    int         base;
    t1_exp = '{5'h15, 5'h0A, 5'h0F};
    bus.pix_valid = 1'b0;
    bus.pix_first = 1'b0;
    bus.pix_data  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset values
    check("rst_write_mode", bus.write_mode, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_reset_write_ptr", bus.reset_write_ptr, 0);
    check("rst_write_data_out", bus.write_data_out, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_window_open", window_open, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_pix_ready", bus.pix_ready, 1);

    // Three pixels, one window
    push_pix(1'b1, 4'h5);
    push_pix(1'b0, 4'hA);
    push_pix(1'b0, 4'hF);
    check("t1_level", fifo_level, 3);
    strobe_log.delete();
    v_sync = 1'b1;
    cycles(3);
    v_sync = 1'b0;
    wait_wm_fall("t1_write_mode_fall", 150);
    check("t1_strobe_count", strobe_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t1_strobe_seq", (i < strobe_log.size()) ? 32'(strobe_log[i]) : 32'hDEAD, t1_exp[i]);
    check("t1_level_empty", fifo_level, 0);
    check("t1_window_still_open", window_open, 1);

    // Fill to full with no window, hold a push, then drain
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) push_pix(1'(i == 0), 4'($urandom));
    check("t2_pix_ready_full", bus.pix_ready, 0);
    check("t2_level_full", fifo_level, DEPTH);
    bus.pix_valid = 1'b1;
    bus.pix_first = 1'b0;
    bus.pix_data  = 4'h3;
    cycles(5);
    check("t2_level_held", fifo_level, DEPTH);
    base = n_strobes;
    v_sync = 1'b1;
    push_pix(1'b0, 4'h3);
    for (int i = 0; i < 3; i++) push_pix(1'b0, 4'($urandom));
    v_sync = 1'b0;
    wait_wm_fall("t2_write_mode_fall", 200);
    check("t2_strobe_count", n_strobes - base, 20);
    check("t2_level_empty", fifo_level, 0);

    // Level 8, then a random stream across the whole window
    do_reset();
    for (int i = 0; i < 8; i++) push_pix(1'b0, 4'($urandom));
    check("t3_level8", fifo_level, 8);
    coinc = 0;
    base = n_strobes;
    for (int i = 0; i < 260; i++) begin
      v_sync = (i >= 2 && i < 6);
      bus.pix_valid = ($urandom_range(0, 2) == 0);
      bus.pix_first = ($urandom_range(0, 7) == 0);
      bus.pix_data  = 4'($urandom);
      cycles(1);
    end
    bus.pix_valid = 1'b0;
    check("t3_push_pop_same_cycle", 32'(coinc > 0), 1);
    check("t3_strobes", 32'(n_strobes - base > 10), 1);
    check("t3_write_mode_after", bus.write_mode, 0);
    check("t3_window_closed", window_open, 0);
    check("t3_no_ack_error", ack_error, 0);

    // Silent framebuffer in WAIT_ACK
    do_reset();
    push_pix(1'b1, 4'h7);
    silent = 1'b1;
    v_sync = 1'b1;
    cycles(3);
    v_sync = 1'b0;
    wait_strobe("t4_strobe");
    cycles(62);
    check("t4_ack_error_early", ack_error, 0);
    check("t4_write_mode_waiting", bus.write_mode, 1);
    cycles(2);
    check("t4_ack_error", ack_error, 1);
    check("t4_write_mode_exit", bus.write_mode, 0);
    cycles(5);
    check("t4_idle_write_mode", bus.write_mode, 0);
    check("t4_level", fifo_level, 0);
    silent = 1'b0;

    // Reset while waiting for an ack
    do_reset();
    push_pix(1'b1, 4'h9);
    push_pix(1'b0, 4'h6);
    v_sync = 1'b1;
    cycles(3);
    v_sync = 1'b0;
    wait_strobe("t5_strobe");
    rst = 1'b1;
    cycles(1);
    check("t5_write_mode", bus.write_mode, 0);
    check("t5_write_data", bus.write_data, 0);
    check("t5_reset_write_ptr", bus.reset_write_ptr, 0);
    check("t5_write_data_out", bus.write_data_out, 0);
    check("t5_window_open", window_open, 0);
    check("t5_ack_error", ack_error, 0);
    check("t5_fifo_level", fifo_level, 0);
    check("t5_pix_ready", bus.pix_ready, 1);
    rst = 1'b0;
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
